// File: rtl/et_pkg.sv
// Shared types and constants for the bounded-eventually monitor.
package et_pkg;

    localparam int unsigned DEFAULT_MAX_DELAY = 4;
    localparam int unsigned REM_W             = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/et_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module et_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;
    logic         w_full;

    assign w_full = &r_count;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_inc && !w_full) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/et_bounded_monitor.sv
// Checks "a implies b within MAX_DELAY cycles" over a sampled a/b trace, closed by eot.
module et_bounded_monitor
    import et_pkg::*;
#(
    parameter int unsigned MAX_DELAY = DEFAULT_MAX_DELAY,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_eot,
    output logic             o_pending,
    output logic [REM_W-1:0] o_remaining,
    output logic             o_pass_pulse,
    output logic             o_fail_pulse,
    output logic             o_violation,
    output logic [CNT_W-1:0] o_fail_count,
    output logic             o_done
);

    generate
        if (MAX_DELAY < 1 || MAX_DELAY > 255) begin : g_bad_max_delay
            $error("et_bounded_monitor: MAX_DELAY must be in 1..255");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("et_bounded_monitor: CNT_W must be at least 1");
        end
    endgenerate

    localparam logic [REM_W-1:0] MAX_REM = REM_W'(MAX_DELAY);
    localparam logic [REM_W-1:0] REM_ONE = REM_W'(1);

    state_e           r_state;
    state_e           w_state_d;
    logic [REM_W-1:0] r_rem;
    logic [REM_W-1:0] w_rem_d;
    logic             r_pass;
    logic             r_fail;
    logic             r_violation;
    logic             w_pass_d;
    logic             w_fail_d;

    always_comb begin
        w_state_d = r_state;
        w_rem_d   = r_rem;
        w_pass_d  = 1'b0;
        w_fail_d  = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_a) begin
                    if (i_b) begin
                        w_pass_d = 1'b1;
                    end else begin
                        w_state_d = WAIT;
                        w_rem_d   = MAX_REM;
                    end
                end
            end
            WAIT: begin
                // A concurrent a is either discharged by this b or subsumed by the older deadline.
                if (i_b) begin
                    w_pass_d  = 1'b1;
                    w_state_d = IDLE;
                    w_rem_d   = '0;
                end else if (r_rem > REM_ONE) begin
                    w_rem_d = r_rem - REM_ONE;
                end else begin
                    w_fail_d = 1'b1;
                    if (i_a) begin
                        w_rem_d = MAX_REM;
                    end else begin
                        w_state_d = IDLE;
                        w_rem_d   = '0;
                    end
                end
            end
            DONE: begin
            end
            default: begin
                w_state_d = IDLE;
                w_rem_d   = '0;
            end
        endcase

        // eot closes the trace; an expiry and an unresolved obligation share one fail.
        if (i_eot && (r_state != DONE)) begin
            if (w_state_d == WAIT) begin
                w_fail_d = 1'b1;
            end
            w_state_d = DONE;
            w_rem_d   = '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_violation <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_rem       <= w_rem_d;
            r_pass      <= w_pass_d;
            r_fail      <= w_fail_d;
            r_violation <= r_violation | w_fail_d;
        end
    end

    et_sat_counter #(
        .W (CNT_W)
    ) u_fail_counter (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_inc   (w_fail_d),
        .o_count (o_fail_count)
    );

    assign o_pending    = (r_state == WAIT);
    assign o_done       = (r_state == DONE);
    assign o_remaining  = r_rem;
    assign o_pass_pulse = r_pass;
    assign o_fail_pulse = r_fail;
    assign o_violation  = r_violation;

endmodule

// File: tb/tb_et_bounded_monitor.sv
// Scoreboard bench: an absolute-deadline reference model predicts every post-edge output.
module tb_et_bounded_monitor;

    localparam int unsigned MAX_DELAY = 4;
    localparam int unsigned CNT_W     = 8;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             a     = 1'b0;
    logic             b     = 1'b0;
    logic             eot   = 1'b0;
    logic             pending;
    logic [7:0]       remaining;
    logic             pass_pulse;
    logic             fail_pulse;
    logic             violation;
    logic [CNT_W-1:0] fail_count;
    logic             done;

    et_bounded_monitor #(
        .MAX_DELAY (MAX_DELAY),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_a          (a),
        .i_b          (b),
        .i_eot        (eot),
        .o_pending    (pending),
        .o_remaining  (remaining),
        .o_pass_pulse (pass_pulse),
        .o_fail_pulse (fail_pulse),
        .o_violation  (violation),
        .o_fail_count (fail_count),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pending;
        int remaining;
        int pass_p;
        int fail_p;
        int viol;
        int count;
        int done;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: obligation held as an absolute deadline cycle.
    bit m_open;
    int m_deadline;
    int m_n;
    bit m_done;
    bit m_viol;
    int m_count;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_open     = 1'b0;
        m_deadline = 0;
        m_n        = 0;
        m_done     = 1'b0;
        m_viol     = 1'b0;
        m_count    = 0;
    endfunction

    function automatic void model_edge(input bit ia, input bit ib, input bit ie);
        exp_t e;
        bit   p = 1'b0;
        bit   f = 1'b0;
        if (!m_done) begin
            if (m_open) begin
                if (ib) begin
                    p      = 1'b1;
                    m_open = 1'b0;
                end else if (m_n == m_deadline) begin
                    f      = 1'b1;
                    m_open = 1'b0;
                    if (ia) begin
                        m_open     = 1'b1;
                        m_deadline = m_n + MAX_DELAY;
                    end
                end
            end else if (ia) begin
                if (ib) begin
                    p = 1'b1;
                end else begin
                    m_open     = 1'b1;
                    m_deadline = m_n + MAX_DELAY;
                end
            end
            if (ie) begin
                if (m_open) f = 1'b1;
                m_open = 1'b0;
                m_done = 1'b1;
            end
            if (f) begin
                m_viol = 1'b1;
                if (m_count < CNT_MAX) m_count++;
            end
        end
        e.pending   = m_open ? 1 : 0;
        e.remaining = m_open ? (m_deadline - m_n) : 0;
        e.pass_p    = p ? 1 : 0;
        e.fail_p    = f ? 1 : 0;
        e.viol      = m_viol ? 1 : 0;
        e.count     = m_count;
        e.done      = m_done ? 1 : 0;
        sb_q.push_back(e);
        m_n++;
    endfunction

    // Monitor: compares the DUT outputs against the oldest prediction each falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("pending", int'(pending), e.pending);
            check("remaining", int'(remaining), e.remaining);
            check("pass_pulse", int'(pass_pulse), e.pass_p);
            check("fail_pulse", int'(fail_pulse), e.fail_p);
            check("violation", int'(violation), e.viol);
            check("fail_count", int'(fail_count), e.count);
            check("done", int'(done), e.done);
        end
    end

    task automatic step(input bit ia, input bit ib, input bit ie);
        a   = ia;
        b   = ib;
        eot = ie;
        @(posedge clk);
        model_edge(ia, ib, ie);
        #1;
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        drain();
        rst_n = 1'b0;
        a     = 1'b0;
        b     = 1'b0;
        eot   = 1'b0;
        model_reset();
        #1;
        check("reset_pending", int'(pending), 0);
        check("reset_remaining", int'(remaining), 0);
        check("reset_pass", int'(pass_pulse), 0);
        check("reset_fail", int'(fail_pulse), 0);
        check("reset_violation", int'(violation), 0);
        check("reset_fail_count", int'(fail_count), 0);
        check("reset_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Quiet trace closed by eot, then frozen.
        repeat (10) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        drain();
        check("quiet_done", int'(done), 1);
        check("quiet_fail_count", int'(fail_count), 0);

        // Discharge at E3.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        drain();
        check("discharge_violation", int'(violation), 0);

        // Expiry, then a same-cycle pass leaves the count alone.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        drain();
        check("expiry_fail_count", int'(fail_count), 1);

        // Re-trigger while waiting is subsumed; re-trigger on the expiry edge re-arms.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        // Unresolved at eot, then frozen against toggling.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (6) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)));

        // Expiry coinciding with eot (and a new trigger) yields a single fail.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        drain();
        check("coincide_fail_count", int'(fail_count), 1);

        // Saturation, then an asynchronous reset mid-obligation.
        do_reset();
        repeat (4 * 256 + 2) step(1'b1, 1'b0, 1'b0);
        drain();
        check("sat_fail_count", int'(fail_count), CNT_MAX);
        check("sat_violation", int'(violation), 1);
        check("pre_reset_pending", int'(pending), 1);
        do_reset();
        repeat (6) step(1'b0, 1'b0, 1'b0);

        // Random traces.
        for (int seg = 0; seg < 8; seg++) begin
            do_reset();
            for (int i = 0; i < 150; i++) begin
                step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0),
                     1'($urandom_range(0, 99) == 0));
            end
        end

        drain();
        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/et_bounded_monitor.md
Name: et_bounded_monitor

Overview:
- Checker that consumes the two-signal stimulus stream (a, b) that our bitvector benches drive into a DUT.
- Enforces the bounded-eventually property "a implies b within MAX_DELAY cycles".
- Reports pass/fail events, a sticky violation flag and a saturating failure count.
- Sits beside the DUT in the ET bench and observes the same a/b nets.

Parameters:
- MAX_DELAY, 4: b must be sampled high within this many cycles after a triggering sample; legal range 1..255; 0 is an elaboration error.
- CNT_W, 8: width of fail_count.

Ports:
- clock  input  1  single clock; all sampling on posedge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- a  input  1  trigger; obligation created when sampled 1
- b  input  1  response; discharges the pending obligation when sampled 1
- eot  input  1  end-of-trace strobe; closes the check
- pending  output  1  obligation outstanding
- remaining  output  8  cycles left for the outstanding obligation, 0 when idle
- pass_pulse  output  1  one-cycle pulse, obligation discharged
- fail_pulse  output  1  one-cycle pulse, obligation expired or unresolved at eot
- violation  output  1  sticky; set on any fail
- fail_count  output  CNT_W  number of fails, saturating at all-ones
- done  output  1  eot seen; monitor frozen

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0, including remaining, violation, fail_count and done.
- All outputs are registered. An event sampled at edge En appears on the outputs in the cycle after En.
- States are IDLE, WAIT and DONE. At most one obligation is outstanding; the earliest deadline governs.
- IDLE:
  - a=1, b=1: pass_pulse; stay IDLE (same-cycle discharge).
  - a=1, b=0: go to WAIT with remaining=MAX_DELAY.
  - otherwise: no action.
- WAIT, per edge:
  - b=1: pass_pulse; go to IDLE. The sample is treated as a=0, because the same b also discharges a simultaneous new a.
  - b=0 and remaining>1: remaining decrements. Any a=1 is ignored, since it is subsumed by the earlier deadline.
  - b=0 and remaining==1: fail_pulse; violation=1; fail_count increments.
    - If a=1 on that same sample: go to WAIT again with remaining=MAX_DELAY.
    - Otherwise: go to IDLE.
- Timing: a=1, b=0 sampled at E0 means b must be seen at one of E1..E_MAX_DELAY. If it is not, fail_pulse is high in the cycle after E_MAX_DELAY.
- eot=1 sampled in IDLE or WAIT:
  - First apply the normal a/b evaluation for that sample.
  - Then, if any obligation remains open (including one newly created by a=1, b=0), issue one fail_pulse for it: violation=1 and fail_count increments.
  - Go to DONE: done=1, pending=0, remaining=0.
  - At most one fail_pulse is issued per eot edge, even when an expiry and an eot-unresolved fail coincide. In that case fail_count increments by 1 only.
- DONE: a, b and eot are ignored; all outputs hold and pulses stay 0 until reset.
- pending=1 exactly in WAIT. remaining mirrors the internal counter.
- fail_count saturates at 2^CNT_W-1; violation stays set regardless.
- Reset asserted mid-obligation clears everything immediately; no fail is reported for the abandoned obligation.
- pass_pulse and fail_pulse are never high in the same cycle.

Decomposition:
- Package et_pkg holds:
  - state enum {IDLE, WAIT, DONE};
  - default MAX_DELAY constant;
  - remaining width constant (8).
- One sub-module: et_sat_counter, a parameterised-width saturating incrementer with async active-low clear. It is used for fail_count.
- The FSM and countdown stay in et_bounded_monitor.

Test Plan (MAX_DELAY=4, CNT_W=8):
- All-zero trace, then eot at cycle 10 -> no pass_pulse, no fail_pulse, violation=0, fail_count=0, done=1.
- a=1 at E0, b=1 at E3 -> pending high from E0 until E3; remaining reads 4,3,2 over E0-E2; pass_pulse after E3; violation=0.
- a=1 at E0, b=0 through E4 -> fail_pulse in the cycle after E4, violation=1, fail_count=1. Then a=1, b=1 -> pass_pulse, count unchanged.
- a=1 at E0, a=1 again at E2, b never -> a single fail after E4. Retrigger a=1 exactly at E4 -> fail, then new WAIT with remaining=4.
- a=1, b=0 at E0, eot at E2 -> fail_pulse, fail_count=1, done=1. Later a/b toggling leaves outputs frozen.
- Force 256 expiries -> fail_count holds 255. Assert reset mid-WAIT -> all outputs 0 asynchronously with no fail_pulse.
